inv_mixcol: RTL and testbench
=============================

# inv_mixcol

Sequential AES InvMixColumns stage for the decryption datapath, the inverse of the existing `mixcol` encryption step. It takes a 128-bit state, multiplies each column by the inverse MixColumns matrix over GF(2^8), and reports completion with the same enable/finished handshake that `mixcol` uses. The default build processes one column per clock to reduce GF multiplier area. The decryption controller sequences it after inverse AddRoundKey.

## Interface
- Parameters: none.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `inv_mixcol_enable`  input  1  level request; must stay high until `inv_mixcol_finished` is seen.
- `olddata`  input  128  input state, row-major: row r, column c byte = bits [127-8*(4r+c) -: 8].
- `newdata`  output  128  result state, same packing; registered.
- `inv_mixcol_finished`  output  1  registered done flag.

## Operation
- States: IDLE, COL0, COL1, COL2, COL3, DONE.
- IDLE with `inv_mixcol_enable`=1 -> capture `olddata` into the working register and go to COL0. `olddata` is ignored after capture.
- COLc computes output column c = M⁻¹ · (b0,b1,b2,b3) with rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
  - Result bytes are written back into column c of the working register.
  - COLc -> COL(c+1). COL3 -> DONE.
- COL3 exit loads the full working register into `newdata` and sets `inv_mixcol_finished`=1.
- DONE holds `inv_mixcol_finished`=1 while enable stays high. Enable=0 -> IDLE and `inv_mixcol_finished`=0.
- GF arithmetic: xtime(a) = (a<<1) ^ (a[7] ? 8'h1b : 0), truncated to 8 bits.
  - 09=x8^x, 0b=x8^x2^x, 0d=x8^x4^x, 0e=x8^x4^x2, where xN is repeated xtime.
  - Pure XOR/shift logic. No lookup ROM.
- Abort: enable=0 in any COLc state -> IDLE on the next edge. `newdata` is unchanged and `inv_mixcol_finished` stays 0.
- Enable held high in DONE does not restart the operation. Enable must drop for at least one cycle before the next request.
- `newdata` holds its last completed result through IDLE and subsequent aborts. It changes only on completion.

## Timing
- Reset (async, immediate): state=IDLE, `newdata`=128'h0, `inv_mixcol_finished`=0, working register=0.
- Enable sampled high in IDLE at edge k -> `newdata` valid and `inv_mixcol_finished`=1 after edge k+4. Latency is 5 edges from the request edge, including the capture edge.
- `inv_mixcol_finished` falls after the first edge at which enable is sampled low in DONE.
- Reset asserted mid-operation overrides everything. The bench sees reset values within the same cycle.
- Minimum back-to-back period: 6 cycles (5 to complete plus 1 with enable low).

## Configuration
- `INV_MIXCOL_PARALLEL_EN` defined:
  - Four column datapaths are instantiated. States COL0–COL3 are removed.
  - IDLE with enable=1 at edge k -> `newdata` = InvMixColumns(`olddata`) and `inv_mixcol_finished`=1 after edge k.
  - Latency is 1 edge. DONE, abort and handshake rules are otherwise unchanged.
- Not defined: one shared column datapath with the 5-edge latency described above.

## Test plan
- FIPS-197 vector: `olddata`=128'h04e0482866cbf8068119d326e59a7a4c, enable held high -> `newdata`=128'hd4e0b81ebfb441275d52119830aef1e5 with `inv_mixcol_finished`=1 exactly 5 edges after request (1 edge with `INV_MIXCOL_PARALLEL_EN`).
- Fixed-point columns: all-8'h01 state -> identical output; all-8'hc6 state -> identical output.
- Single known column: column 0 = (8e,4d,a1,bc), other columns 0 -> column 0 of `newdata` = (db,13,53,45), other columns 0.
- Abort: drop enable in COL2 -> `inv_mixcol_finished` never rises and `newdata` keeps the previous result. The next full request completes normally.
- Handshake: hold enable 10 cycles past finished -> `inv_mixcol_finished` stays 1 and there is no recomputation even if `olddata` changes. Enable low -> finished is 0 after one edge.
- Reset mid-COL1 -> `newdata`=0, `inv_mixcol_finished`=0 asynchronously. After release, a new request produces the correct result.

Source files
------------

// File: rtl/inv_mixcol.sv
// AES InvMixColumns stage with an enable/finished handshake. One column per clock by default;
// define INV_MIXCOL_PARALLEL_EN to transform all four columns in a single edge.

module inv_mixcol_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // k selects which of a, x2, x4, x8 are XORed together, so 09/0b/0d/0e are pure XOR trees
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  // Circulant matrix: the coefficient depends only on (column - row) mod 4
  function automatic logic [3:0] coef(input logic [1:0] n);
    case (n)
      2'd0:    return 4'he;
      2'd1:    return 4'hb;
      2'd2:    return 4'hd;
      default: return 4'h9;
    endcase
  endfunction

  always_comb begin
    logic [7:0] acc;
    col_o = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++)
        acc = acc ^ gmul(col_i[31-8*j -: 8], coef(2'(j - i)));
      col_o[31-8*i -: 8] = acc;
    end
  end
endmodule

module inv_mixcol (
  input  logic         clk,
  input  logic         rst,
  input  logic         inv_mixcol_enable,
  input  logic [127:0] olddata,
  output logic [127:0] newdata,
  output logic         inv_mixcol_finished
);
  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[31-8*r -: 8] = s[127-8*(4*r+int'(c)) -: 8];
    return v;
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] v);
    logic [127:0] o;
    o = s;
    for (int r = 0; r < 4; r++) o[127-8*(4*r+int'(c)) -: 8] = v[31-8*r -: 8];
    return o;
  endfunction

`ifdef INV_MIXCOL_PARALLEL_EN
  typedef enum logic {IDLE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, COL0, COL1, COL2, COL3, DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [127:0]   newdata_q, newdata_d;
  logic           fin_q, fin_d;
  logic           load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef INV_MIXCOL_PARALLEL_EN
  logic [3:0][31:0] pcol_in, pcol_out;
  logic [127:0]     mix_all;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inv_mixcol_enable)  state_d = DONE;
      DONE:    if (!inv_mixcol_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb load = (state_q == IDLE) && inv_mixcol_enable;

  for (genvar g = 0; g < 4; g++) begin : g_col
    inv_mixcol_col u_col (.col_i(pcol_in[g]), .col_o(pcol_out[g]));
  end

  always_comb begin
    mix_all = '0;
    for (int c = 0; c < 4; c++) begin
      pcol_in[c] = get_col(olddata, 2'(c));
      mix_all    = set_col(mix_all, 2'(c), pcol_out[c]);
    end
  end

  always_comb newdata_d = load ? mix_all : newdata_q;
`else
  logic [127:0] work_q, work_d;
  logic         cap, wr;
  logic [1:0]   col_sel;
  logic [31:0]  col_in, col_out;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inv_mixcol_enable) state_d = COL0;
      COL0:    state_d = inv_mixcol_enable ? COL1 : IDLE;
      COL1:    state_d = inv_mixcol_enable ? COL2 : IDLE;
      COL2:    state_d = inv_mixcol_enable ? COL3 : IDLE;
      COL3:    state_d = inv_mixcol_enable ? DONE : IDLE;
      DONE:    if (!inv_mixcol_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An abort (enable low in a COL state) suppresses every write so newdata keeps its old result
  always_comb begin
    cap     = 1'b0;
    wr      = 1'b0;
    load    = 1'b0;
    col_sel = 2'd0;
    case (state_q)
      IDLE: cap = inv_mixcol_enable;
      COL0: begin wr = inv_mixcol_enable; col_sel = 2'd0; end
      COL1: begin wr = inv_mixcol_enable; col_sel = 2'd1; end
      COL2: begin wr = inv_mixcol_enable; col_sel = 2'd2; end
      COL3: begin wr = inv_mixcol_enable; col_sel = 2'd3; load = inv_mixcol_enable; end
      default: ;
    endcase
  end

  assign col_in = get_col(work_q, col_sel);

  inv_mixcol_col u_col (.col_i(col_in), .col_o(col_out));

  always_comb begin
    work_d    = work_q;
    newdata_d = newdata_q;
    if (cap)     work_d = olddata;
    else if (wr) work_d = set_col(work_q, col_sel, col_out);
    if (load)    newdata_d = work_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) work_q <= '0;
    else     work_q <= work_d;
  end
`endif

  assign fin_d = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      newdata_q <= '0;
      fin_q     <= 1'b0;
    end else begin
      newdata_q <= newdata_d;
      fin_q     <= fin_d;
    end
  end

  assign newdata             = newdata_q;
  assign inv_mixcol_finished = fin_q;
endmodule

// File: tb/tb_inv_mixcol.sv
// Self-checking bench for inv_mixcol: scoreboard of reference InvMixColumns results,
// checked for latency, data, abort, handshake and asynchronous reset behaviour.

module tb_inv_mixcol;
`ifdef INV_MIXCOL_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 5;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [127:0] olddata = '0;
  logic [127:0] newdata;
  logic         fin;

  int           checks   = 0;
  int           failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_res = '0;

  inv_mixcol dut (
    .clk                 (clk),
    .rst                 (rst),
    .inv_mixcol_enable   (en),
    .olddata             (olddata),
    .newdata             (newdata),
    .inv_mixcol_finished (fin)
  );

  always #5 clk = ~clk;

  // Shift-and-add GF(2^8) multiply, reduction polynomial 0x11b
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [7:0]   m [4][4];
    logic [127:0] o;
    logic [7:0]   acc;
    m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
          '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(m[r][j], s[127-8*(4*j+c) -: 8]);
        o[127-8*(4*r+c) -: 8] = acc;
      end
    return o;
  endfunction

  // Raise enable, wait for finished, check latency and pop the expected result; leaves enable high
  task automatic start_and_wait(input logic [127:0] d, input logic [127:0] exp_v, input string nm);
    int n;
    logic [127:0] e;
    olddata = d;
    en = 1'b1;
    exp_q.push_back(exp_v);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (fin === 1'b1) break;
      if (n > 20) break;
    end
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges, expected %0d", nm, n, LAT);
    end
    e = exp_q.pop_front();
    checks++;
    if (newdata !== e) begin
      failures++;
      $display("FAIL %s_data: got %h, expected %h", nm, newdata, e);
    end
    last_res = e;
  endtask

  task automatic release_en(input string nm);
    en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (fin !== 1'b0) begin
      failures++;
      $display("FAIL %s_fin_drop: got %b, expected 0", nm, fin);
    end
    checks++;
    if (newdata !== last_res) begin
      failures++;
      $display("FAIL %s_hold: got %h, expected %h", nm, newdata, last_res);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (newdata !== 128'h0) begin
      failures++;
      $display("FAIL reset_newdata: got %h, expected 0", newdata);
    end
    checks++;
    if (fin !== 1'b0) begin
      failures++;
      $display("FAIL reset_fin: got %b, expected 0", fin);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fips();
    start_and_wait(128'h04e0482866cbf8068119d326e59a7a4c,
                   128'hd4e0b81ebfb441275d52119830aef1e5, "fips");
    release_en("fips");
  endtask

  task automatic test_fixed_points();
    start_and_wait({16{8'h01}}, {16{8'h01}}, "fix01");
    release_en("fix01");
    start_and_wait({16{8'hc6}}, {16{8'hc6}}, "fixc6");
    release_en("fixc6");
  endtask

  task automatic test_single_col();
    logic [127:0] d, e;
    d = '0; e = '0;
    d[127:120] = 8'h8e; d[95:88] = 8'h4d; d[63:56] = 8'ha1; d[31:24] = 8'hbc;
    e[127:120] = 8'hdb; e[95:88] = 8'h13; e[63:56] = 8'h53; e[31:24] = 8'h45;
    start_and_wait(d, e, "onecol");
    release_en("onecol");
  endtask

  task automatic test_random();
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      start_and_wait(d, ref_mix(d), "rand");
      release_en("rand");
    end
  endtask

  task automatic test_abort();
`ifndef INV_MIXCOL_PARALLEL_EN
    logic bad_fin, bad_data;
    bad_fin = 0; bad_data = 0;
    olddata = 128'h0123456789abcdeffedcba9876543210;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (fin !== 1'b0) bad_fin = 1;
      if (newdata !== last_res) bad_data = 1;
    end
    checks++;
    if (bad_fin) begin
      failures++;
      $display("FAIL abort_fin: got finished=1, expected 0");
    end
    checks++;
    if (bad_data) begin
      failures++;
      $display("FAIL abort_hold: got %h, expected %h", newdata, last_res);
    end
`endif
    start_and_wait(128'h0123456789abcdeffedcba9876543210,
                   ref_mix(128'h0123456789abcdeffedcba9876543210), "after_abort");
    release_en("after_abort");
  endtask

  task automatic test_handshake();
    logic bad_fin, bad_data;
    bad_fin = 0; bad_data = 0;
    start_and_wait(128'h00112233445566778899aabbccddeeff,
                   ref_mix(128'h00112233445566778899aabbccddeeff), "hs");
    repeat (10) begin
      olddata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (fin !== 1'b1) bad_fin = 1;
      if (newdata !== last_res) bad_data = 1;
    end
    checks++;
    if (bad_fin) begin
      failures++;
      $display("FAIL hs_fin_hold: got finished=0, expected 1");
    end
    checks++;
    if (bad_data) begin
      failures++;
      $display("FAIL hs_no_recompute: got %h, expected %h", newdata, last_res);
    end
    release_en("hs");
  endtask

  task automatic test_back_to_back();
    start_and_wait(128'hdb135345f20a225c01010101c6c6c6c6,
                   ref_mix(128'hdb135345f20a225c01010101c6c6c6c6), "b2b0");
    release_en("b2b0");
    start_and_wait(128'hffeeddccbbaa99887766554433221100,
                   ref_mix(128'hffeeddccbbaa99887766554433221100), "b2b1");
    release_en("b2b1");
  endtask

  task automatic test_reset_mid();
    olddata = 128'h0f0e0d0c0b0a09080706050403020100;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (newdata !== 128'h0) begin
      failures++;
      $display("FAIL rstmid_newdata: got %h, expected 0", newdata);
    end
    checks++;
    if (fin !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_fin: got %b, expected 0", fin);
    end
    en = 1'b0;
    last_res = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    start_and_wait(128'h0f0e0d0c0b0a09080706050403020100,
                   ref_mix(128'h0f0e0d0c0b0a09080706050403020100), "after_rst");
    release_en("after_rst");
  endtask

  initial begin
    test_reset();
    test_fips();
    test_fixed_points();
    test_single_col();
    test_random();
    test_abort();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
